// File: rtl/psum_drain_fifo_if.sv
// Handshake/data bundle between a mac_tile column's south psum output, the
// psum_drain_fifo below it and the downstream reader.
interface psum_drain_fifo_if #(
    parameter int psum_bw = 16,
    parameter int idx_bw  = 8
);
    logic [psum_bw-1:0] in_s;
    logic               wr;
    logic               rd;
    logic               clear;
    logic [psum_bw-1:0] out;
    logic               o_valid;
    logic               o_full;
    logic               o_empty;
    logic [psum_bw-1:0] max_val;
    logic [idx_bw-1:0]  max_idx;

    modport master (
        output in_s, wr, rd, clear,
        input  out, o_valid, o_full, o_empty, max_val, max_idx
    );

    modport slave (
        input  in_s, wr, rd, clear,
        output out, o_valid, o_full, o_empty, max_val, max_idx
    );
endinterface

// File: rtl/psum_drain_fifo.sv
// Buffers a mac_tile column's south psum stream in a circular FIFO; with
// DRAIN_MAX_TRACK_EN defined it also tracks the largest signed psum and its index.
module psum_drain_fifo #(
    parameter int psum_bw = 16,
    parameter int depth   = 8,
    parameter int idx_bw  = 8
) (
    input  logic              clk,
    input  logic              reset,
    psum_drain_fifo_if.slave  bus
);
    localparam int ptr_bw = $clog2(depth);
    localparam int cnt_bw = ptr_bw + 1;

    logic [psum_bw-1:0] mem [depth];
    logic [ptr_bw-1:0]  wr_ptr;
    logic [ptr_bw-1:0]  rd_ptr;
    logic [cnt_bw-1:0]  count;
    logic [cnt_bw-1:0]  count_next;
    logic               full_r;
    logic               empty_r;
    logic               rd_accept;
    logic               wr_accept;
    logic [psum_bw-1:0] out_r;
    logic               valid_r;

    // A read frees a slot in the same cycle, so a full FIFO still accepts a write alongside it.
    always_comb begin
        rd_accept  = bus.rd && !empty_r;
        wr_accept  = bus.wr && (!full_r || rd_accept);
        count_next = count;
        if (wr_accept && !rd_accept)
            count_next = count + cnt_bw'(1);
        else if (rd_accept && !wr_accept)
            count_next = count - cnt_bw'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            full_r  <= 1'b0;
            empty_r <= 1'b1;
        end else begin
            if (wr_accept)
                wr_ptr <= wr_ptr + ptr_bw'(1);
            if (rd_accept)
                rd_ptr <= rd_ptr + ptr_bw'(1);
            count   <= count_next;
            full_r  <= (count_next == cnt_bw'(depth));
            empty_r <= (count_next == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && wr_accept)
            mem[wr_ptr] <= bus.in_s;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_r   <= '0;
            valid_r <= 1'b0;
        end else begin
            valid_r <= rd_accept;
            if (rd_accept)
                out_r <= mem[rd_ptr];
        end
    end

    assign bus.out     = out_r;
    assign bus.o_valid = valid_r;
    assign bus.o_full  = full_r;
    assign bus.o_empty = empty_r;

`ifdef DRAIN_MAX_TRACK_EN
    logic [idx_bw-1:0]  seq_cnt;
    logic [idx_bw-1:0]  max_idx_r;
    logic [psum_bw-1:0] max_val_r;
    logic               seeded;

    // Strict greater-than keeps the earliest index on ties; clear beats a concurrent write.
    always_ff @(posedge clk) begin
        if (reset || bus.clear) begin
            seq_cnt   <= '0;
            max_idx_r <= '0;
            max_val_r <= '0;
            seeded    <= 1'b0;
        end else if (wr_accept) begin
            seq_cnt <= seq_cnt + idx_bw'(1);
            if (!seeded || ($signed(bus.in_s) > $signed(max_val_r))) begin
                max_val_r <= bus.in_s;
                max_idx_r <= seq_cnt;
                seeded    <= 1'b1;
            end
        end
    end

    assign bus.max_val = max_val_r;
    assign bus.max_idx = max_idx_r;
`else
    logic unused_clear;

    assign unused_clear = bus.clear;
    assign bus.max_val  = '0;
    assign bus.max_idx  = '0;
`endif
endmodule

// File: tb/tb_psum_drain_fifo.sv
// Directed bench for psum_drain_fifo; max-tracker expectations follow DRAIN_MAX_TRACK_EN.
module tb_psum_drain_fifo;
`ifdef DRAIN_MAX_TRACK_EN
    localparam bit track_en = 1'b1;
`else
    localparam bit track_en = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   tests_run    = 0;
    int   tests_failed = 0;

    int t1_data[4] = '{3, -2, 7, 7};
    int t3_data[8] = '{13, 14, 15, 16, 17, 100, 101, 102};
    int t5_data[5] = '{-4, -9, -1, 50, -3};

    psum_drain_fifo_if #(.psum_bw(16), .idx_bw(8)) bus ();

    psum_drain_fifo #(.psum_bw(16), .depth(8), .idx_bw(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] psum(input int v);
        return v[15:0];
    endfunction

    function automatic logic [15:0] exp_max(input int v);
        return track_en ? v[15:0] : 16'd0;
    endfunction

    function automatic logic [7:0] exp_idx(input int v);
        return track_en ? v[7:0] : 8'd0;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the edge.
    task automatic applyStimulus(input logic w, input logic [15:0] d,
                                 input logic r, input logic c);
        bus.wr    = w;
        bus.in_s  = d;
        bus.rd    = r;
        bus.clear = c;
        @(posedge clk);
        #1;
        bus.wr    = 1'b0;
        bus.rd    = 1'b0;
        bus.clear = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        bus.wr    = 1'b0;
        bus.rd    = 1'b0;
        bus.clear = 1'b0;
        bus.in_s  = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_out", bus.out, 0);
        checkOutput("rst_valid", bus.o_valid, 0);
        checkOutput("rst_full", bus.o_full, 0);
        checkOutput("rst_empty", bus.o_empty, 1);
        checkOutput("rst_max_val", bus.max_val, 0);
        checkOutput("rst_max_idx", bus.max_idx, 0);
        reset = 1'b0;

        // Basic fill/drain with a tie on the maximum.
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, psum(t1_data[i]), 1'b0, 1'b0);
        checkOutput("t1_empty", bus.o_empty, 0);
        checkOutput("t1_full", bus.o_full, 0);
        checkOutput("t1_max_val", bus.max_val, exp_max(7));
        checkOutput("t1_max_idx", bus.max_idx, exp_idx(2));
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, '0, 1'b1, 1'b0);
            checkOutput("t1_valid", bus.o_valid, 1);
            checkOutput("t1_out", bus.out, psum(t1_data[i]));
        end
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        checkOutput("t1_valid_idle", bus.o_valid, 0);
        checkOutput("t1_out_hold", bus.out, psum(7));
        checkOutput("t1_empty_end", bus.o_empty, 1);

        // Fill to full, then one dropped write.
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, psum(10 + i), 1'b0, 1'b0);
        checkOutput("t2_full", bus.o_full, 1);
        applyStimulus(1'b1, psum(18), 1'b0, 1'b0);
        checkOutput("t2_full_drop", bus.o_full, 1);
        checkOutput("t2_max_val", bus.max_val, exp_max(17));
        checkOutput("t2_max_idx", bus.max_idx, exp_idx(7));

        // Full with simultaneous read and write, then drain across the wrap.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, psum(100 + i), 1'b1, 1'b0);
            checkOutput("t3_valid", bus.o_valid, 1);
            checkOutput("t3_out", bus.out, psum(10 + i));
            checkOutput("t3_full", bus.o_full, 1);
        end
        checkOutput("t3_max_val", bus.max_val, exp_max(102));
        checkOutput("t3_max_idx", bus.max_idx, exp_idx(10));
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, '0, 1'b1, 1'b0);
            checkOutput("t3_drain_valid", bus.o_valid, 1);
            checkOutput("t3_drain_out", bus.out, psum(t3_data[i]));
        end
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        checkOutput("t3_empty", bus.o_empty, 1);
        checkOutput("t3_not_full", bus.o_full, 0);

        // Empty with simultaneous read and write: no fall-through.
        applyStimulus(1'b1, psum(5), 1'b1, 1'b0);
        checkOutput("t4_valid", bus.o_valid, 0);
        checkOutput("t4_empty", bus.o_empty, 0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("t4_rd_valid", bus.o_valid, 1);
        checkOutput("t4_rd_out", bus.out, psum(5));
        checkOutput("t4_max_val", bus.max_val, exp_max(102));

        // Negative stream, clear racing a write, reseed.
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        checkOutput("t5_clr_val", bus.max_val, 0);
        checkOutput("t5_clr_idx", bus.max_idx, 0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, psum(t5_data[i]), 1'b0, 1'b0);
        checkOutput("t5_neg_val", bus.max_val, exp_max(-1));
        checkOutput("t5_neg_idx", bus.max_idx, exp_idx(2));
        applyStimulus(1'b1, psum(50), 1'b0, 1'b1);
        checkOutput("t5_clrw_val", bus.max_val, 0);
        checkOutput("t5_clrw_idx", bus.max_idx, 0);
        applyStimulus(1'b1, psum(-3), 1'b0, 1'b0);
        checkOutput("t5_seed_val", bus.max_val, exp_max(-3));
        checkOutput("t5_seed_idx", bus.max_idx, exp_idx(0));
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, '0, 1'b1, 1'b0);
            checkOutput("t5_valid", bus.o_valid, 1);
            checkOutput("t5_out", bus.out, psum(t5_data[i]));
        end

        // Reset in the middle of a fill.
        for (int i = 1; i <= 3; i++) applyStimulus(1'b1, psum(i), 1'b0, 1'b0);
        checkOutput("t6_pre_val", bus.max_val, exp_max(3));
        checkOutput("t6_pre_idx", bus.max_idx, exp_idx(3));
        reset    = 1'b1;
        bus.wr   = 1'b1;
        bus.in_s = psum(4);
        @(posedge clk);
        #1;
        reset  = 1'b0;
        bus.wr = 1'b0;
        checkOutput("t6_empty", bus.o_empty, 1);
        checkOutput("t6_full", bus.o_full, 0);
        checkOutput("t6_max_val", bus.max_val, 0);
        checkOutput("t6_max_idx", bus.max_idx, 0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("t6_rd_valid", bus.o_valid, 0);
        checkOutput("t6_rd_out", bus.out, 0);
        checkOutput("t6_rd_empty", bus.o_empty, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/psum_drain_fifo.md
Name: psum_drain_fifo

Overview:
- Receives the partial-sum stream leaving the south edge (`out_s`) of a mac_tile column and buffers it in a small FIFO.
- The buffered sums are drained by the downstream reader.
- While filling, it tracks the largest signed psum and its arrival index. This gives the furthest-neighbour candidate for the column.
- One instance sits below each column of the array; it is the receiving end of the tile's south psum output.

Parameters:
- psum_bw, 16, width of one partial sum (matches mac_tile out_s).
- depth, 8, FIFO entries; must be a power of 2, at least 2.
- idx_bw, 8, width of the arrival-sequence counter and max_idx.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high; clears all state
- in_s  input  psum_bw  psum from the bottom mac_tile out_s, two's complement
- wr  input  1  in_s valid this cycle
- rd  input  1  reader requests one word
- clear  input  1  synchronous clear of max tracker and sequence counter only
- out  output  psum_bw  registered read data
- o_valid  output  1  out holds a newly read word (one-cycle pulse)
- o_full  output  1  FIFO holds depth words
- o_empty  output  1  FIFO holds 0 words
- max_val  output  psum_bw  largest signed psum accepted since reset/clear
- max_idx  output  idx_bw  sequence number of max_val

Behaviour:
- Reset values (reset high at a clock edge): out=0, o_valid=0, o_full=0, o_empty=1, max_val=0, max_idx=0.
  - Pointers, occupancy and sequence counter = 0; tracker "seeded" flag cleared.
  - Reset mid-stream discards all stored words; no output pulse follows.
- Storage: circular buffer with wr_ptr and rd_ptr of log2(depth) bits, wrapping from depth-1 to 0. Occupancy counter spans 0..depth.
- Write accept: wr && (!o_full || rd_accept). The word is stored at wr_ptr, which then advances.
- Read accept: rd && !o_empty. On the next edge, out = mem[rd_ptr], o_valid=1, and rd_ptr advances. Read latency is 1 cycle.
- If rd is not accepted, o_valid=0 and out holds its previous value.
- Simultaneous events:
  - Empty, wr && rd: write accepted, read ignored, o_valid stays 0. There is no fall-through.
  - Full, wr && rd: both accepted, occupancy stays at depth.
  - Full, wr && !rd: write dropped silently; state unchanged, tracker unchanged.
  - Partially filled, wr && rd: both accepted, occupancy unchanged.
- o_full and o_empty are registered and derived from the next-state occupancy, so they are valid in the cycle after the edge.
- Sequence counter:
  - Increments on every accepted write and wraps at 2^idx_bw.
  - Each accepted word is tagged with the pre-increment value.
  - The first word after reset or clear is index 0.
- Max tracker, on an accepted write:
  - If not seeded, or in_s is greater than max_val as a signed compare, load max_val=in_s and max_idx=tag, and set seeded.
  - Ties keep the earlier index.
  - Dropped writes are ignored.
- clear:
  - Zeroes max_val, max_idx, the sequence counter and seeded. FIFO contents and pointers are untouched.
  - If clear and an accepted write occur in the same cycle, clear wins for the tracker; the write still enters the FIFO, and that word is not counted by the tracker.
- reset has priority over clear, wr and rd.

Optional Feature:
- Macro: DRAIN_MAX_TRACK_EN.
- Defined: max tracker and sequence counter are built as described above.
- Undefined: tracker logic and sequence counter are removed; max_val and max_idx are constant 0; clear has no effect. FIFO behaviour is identical in both builds.

Test Plan:
- Reset, then write 3, -2, 7, 7 (wr=1 on four consecutive cycles), then rd on four consecutive cycles.
  - After the writes: o_empty=0, o_full=0.
  - During the reads: o_valid pulses with out = 3, -2, 7, 7, one cycle after each rd.
  - max_val=7, max_idx=2 (tie keeps the earlier index).
- Write 9 words with depth=8, rd=0.
  - o_full=1 after the 8th write; 9th word dropped.
  - Reading 8 words returns words 1..8; sequence counter = 8.
- With the FIFO full, assert wr=1 and rd=1 for 3 cycles with inputs 100, 101, 102.
  - o_full stays 1; out = words 1..3.
  - Subsequent drain ends with 100, 101, 102, exercising pointer wrap.
- With the FIFO empty, assert wr=1 (in_s=5) and rd=1 in the same cycle.
  - o_valid=0 next cycle, occupancy=1.
  - The next rd returns 5.
- All-negative stream -4, -9, -1:
  - max_val=-1, max_idx=2.
  - Pulse clear with a concurrent write of 50: max_val=0, max_idx=0, and 50 is still readable.
  - A following write of -3 gives max_val=-3, max_idx=0.
- Assert reset in the middle of a 5-word fill: o_empty=1, max_val=0, and no o_valid on a following rd.
  - Repeat the run built without DRAIN_MAX_TRACK_EN: max outputs stay 0 throughout.
